debug_display: RTL and testbench

//  Parametrised debug-word viewer that drives the 7-segment bank in place of the
//  ad-hoc SW-selected mux in the board top. Takes NUM_CH packed debug words,

---
 rtl/debug_display_pkg.sv | 28 ++
 rtl/debug_display_scroll_counter.sv | 66 ++++++
 rtl/debug_display.sv | 149 ++++++++++++++
 tb/tb_debug_display.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_display_pkg.sv
// Shared types and sizing helpers for the debug word viewer.
// Mode codes, FSM states and constant functions for derived widths.
package debug_display_pkg;

  localparam logic [1:0] MODE_LIVE = 2'd0;
  localparam logic [1:0] MODE_HOLD = 2'd1;
  localparam logic [1:0] MODE_AUTO = 2'd2;

  typedef enum logic [1:0] {
    ST_LIVE,
    ST_HOLD,
    ST_AUTO
  } state_t;

  // Bits needed to index n items, never less than one.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/debug_display_scroll_counter.sv
// Auto-scroll position: prescaler, then page, then channel wrap.
// Ports: load/ld_* restart position, run advances; *_nxt is the post-edge value.
module scroll_counter
  import debug_display_pkg::*;
#(
  parameter int SCROLL_DIV = 4,
  parameter int NUM_CH     = 5,
  parameter int PAGES      = 2,
  parameter int CH_W       = 3,
  parameter int PAGE_W     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              run,
  input  logic [CH_W-1:0]   ld_ch,
  input  logic [PAGE_W-1:0] ld_page,
  output logic [CH_W-1:0]   ch_nxt,
  output logic [PAGE_W-1:0] page_nxt
);

  localparam int PRE_W = clog2_min1(SCROLL_DIV);

  logic [PRE_W-1:0]  pre_q, pre_nxt;
  logic [CH_W-1:0]   ch_q;
  logic [PAGE_W-1:0] page_q;

  always_comb begin
    pre_nxt  = pre_q;
    ch_nxt   = ch_q;
    page_nxt = page_q;
    if (load) begin
      pre_nxt  = '0;
      ch_nxt   = ld_ch;
      page_nxt = ld_page;
    end else if (run) begin
      if (pre_q == PRE_W'(SCROLL_DIV - 1)) begin
        pre_nxt = '0;
        if (page_q == PAGE_W'(PAGES - 1)) begin
          page_nxt = '0;
          if (ch_q == CH_W'(NUM_CH - 1))
            ch_nxt = '0;
          else
            ch_nxt = ch_q + CH_W'(1);
        end else begin
          page_nxt = page_q + PAGE_W'(1);
        end
      end else begin
        pre_nxt = pre_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      ch_q   <= '0;
      page_q <= '0;
    end else begin
      pre_q  <= pre_nxt;
      ch_q   <= ch_nxt;
      page_q <= page_nxt;
    end
  end

endmodule

// File: rtl/debug_display.sv
// Debug word viewer for the 7-segment bank: live/hold/auto-scroll.
// In: iChannels, iSel, iPage, iMode, iCapture. Out: oDigits, oBlank, oChannel, oPage, oFrozen.
module debug_display
  import debug_display_pkg::*;
#(
  parameter int NUM_CH     = 5,
  parameter int DATA_W     = 64,
  parameter int DIGITS     = 8,
  parameter int SCROLL_DIV = 50_000_000,
  localparam int CH_W      = clog2_min1(NUM_CH),
  localparam int PG_BITS   = 4 * DIGITS,
  localparam int PAGES     = ceil_div(DATA_W, PG_BITS),
  localparam int PAGE_W    = clog2_min1(PAGES)
) (
  input  logic                     iClock,
  input  logic                     iReset,
  input  logic [NUM_CH*DATA_W-1:0] iChannels,
  input  logic [CH_W-1:0]          iSel,
  input  logic [PAGE_W-1:0]        iPage,
  input  logic [1:0]               iMode,
  input  logic                     iCapture,
  output logic [PG_BITS-1:0]       oDigits,
  output logic [DIGITS-1:0]        oBlank,
  output logic [CH_W-1:0]          oChannel,
  output logic [PAGE_W-1:0]        oPage,
  output logic                     oFrozen
);

  localparam int PAD_W = PAGES * PG_BITS;
  localparam logic [DIGITS-1:0] BLANK_RST =
    {DIGITS{1'b1}} << 1;

  state_t state_q, state_d;

  logic [NUM_CH*DATA_W-1:0] snap_q;
  logic                     cap_q;
  logic                     cap_rise;

  logic              auto_load;
  logic              auto_run;
  logic [CH_W-1:0]   ld_ch;
  logic [PAGE_W-1:0] ld_page;
  logic [CH_W-1:0]   auto_ch;
  logic [PAGE_W-1:0] auto_page;

  logic [CH_W-1:0]          disp_ch;
  logic [PAGE_W-1:0]        disp_pg;
  logic [NUM_CH*DATA_W-1:0] src;
  logic [DATA_W-1:0]        word;
  logic [PAD_W-1:0]         padded;
  logic [PG_BITS-1:0]       nib;
  logic [DIGITS-1:0]        blank;
  logic                     zero_run;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) state_q <= ST_LIVE;
    else        state_q <= state_d;
  end

  // Mode is sampled every cycle; the next state also drives
  // this cycle's output mux so outputs lag iMode by one edge.
  always_comb begin
    state_d   = ST_LIVE;
    auto_load = 1'b0;
    auto_run  = 1'b0;
    unique case (1'b1)
      (iMode == MODE_HOLD): state_d = ST_HOLD;
      (iMode == MODE_AUTO): state_d = ST_AUTO;
      default:              state_d = ST_LIVE;
    endcase
    if (state_d == ST_AUTO) begin
      auto_run  = 1'b1;
      auto_load = (state_q != ST_AUTO);
    end
  end

  assign cap_rise = iCapture & ~cap_q;

  assign ld_ch   = (int'(iSel) < NUM_CH) ? iSel : '0;
  assign ld_page = (int'(iPage) < PAGES) ? iPage : '0;

  scroll_counter #(
    .SCROLL_DIV (SCROLL_DIV),
    .NUM_CH     (NUM_CH),
    .PAGES      (PAGES),
    .CH_W       (CH_W),
    .PAGE_W     (PAGE_W)
  ) u_scroll (
    .clk      (iClock),
    .rst      (iReset),
    .load     (auto_load),
    .run      (auto_run),
    .ld_ch    (ld_ch),
    .ld_page  (ld_page),
    .ch_nxt   (auto_ch),
    .page_nxt (auto_page)
  );

  always_comb begin
    disp_ch = iSel;
    disp_pg = iPage;
    if (state_d == ST_AUTO) begin
      disp_ch = auto_ch;
      disp_pg = auto_page;
    end
    src = (state_d == ST_HOLD) ? snap_q : iChannels;
    word = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (disp_ch == CH_W'(k))
        word = src[k*DATA_W +: DATA_W];
    padded = '0;
    padded[DATA_W-1:0] = word;
    nib = '0;
    for (int p = 0; p < PAGES; p++)
      if (disp_pg == PAGE_W'(p))
        nib = padded[p*PG_BITS +: PG_BITS];
  end

  // Walk down from the top digit; blank while all seen are zero.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (nib[4*i +: 4] == 4'h0);
      blank[i] = zero_run;
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      cap_q    <= 1'b0;
      snap_q   <= '0;
      oDigits  <= '0;
      oBlank   <= BLANK_RST;
      oChannel <= '0;
      oPage    <= '0;
      oFrozen  <= 1'b0;
    end else begin
      cap_q <= iCapture;
      if (cap_rise) snap_q <= iChannels;
      oDigits  <= nib;
      oBlank   <= blank;
      oChannel <= disp_ch;
      oPage    <= disp_pg;
      oFrozen  <= (state_d == ST_HOLD);
    end
  end

endmodule

// File: tb/tb_debug_display.sv
// Randomized and directed checks of debug_display against a
// position/arithmetic reference model (NUM_CH=5, 64b, 8 digits, div 4).
module tb_debug_display;

  localparam int NCH = 5;
  localparam int DIV = 4;
  localparam int NPG = 2;

  logic          iClock;
  logic          iReset;
  logic [319:0]  iChannels;
  logic [2:0]    iSel;
  logic [0:0]    iPage;
  logic [1:0]    iMode;
  logic          iCapture;
  logic [31:0]   oDigits;
  logic [7:0]    oBlank;
  logic [2:0]    oChannel;
  logic [0:0]    oPage;
  logic          oFrozen;

  logic [63:0] ch [NCH];
  logic [63:0] m_snap [NCH];
  int          m_prev;
  logic        m_cap;
  int          m_start;
  int          m_t;

  int n_chk;
  int n_fail;

  debug_display #(
    .NUM_CH     (NCH),
    .DATA_W     (64),
    .DIGITS     (8),
    .SCROLL_DIV (DIV)
  ) dut (
    .iClock    (iClock),
    .iReset    (iReset),
    .iChannels (iChannels),
    .iSel      (iSel),
    .iPage     (iPage),
    .iMode     (iMode),
    .iCapture  (iCapture),
    .oDigits   (oDigits),
    .oBlank    (oBlank),
    .oChannel  (oChannel),
    .oPage     (oPage),
    .oFrozen   (oFrozen)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  always_comb begin
    iChannels = '0;
    for (int k = 0; k < NCH; k++)
      iChannels[k*64 +: 64] = ch[k];
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 0;
    m_cap  = 1'b0;
    m_t    = 0;
    m_start = 0;
    for (int k = 0; k < NCH; k++) m_snap[k] = '0;
  endtask

  // One clock: predict from the inputs seen at the edge, then compare.
  task automatic cycle();
    int mode, ech, epg, pos;
    logic [63:0] w;
    logic [31:0] d;
    logic [7:0]  b;
    @(posedge iClock);
    mode = (iMode == 2'd1) ? 1 : (iMode == 2'd2) ? 2 : 0;
    if (mode == 2) begin
      if (m_prev != 2) begin
        m_start = ((int'(iSel) < NCH) ? int'(iSel) : 0) * NPG
                  + int'(iPage);
        m_t = 0;
      end else begin
        m_t++;
      end
      pos = (m_start + m_t / DIV) % (NCH * NPG);
      ech = pos / NPG;
      epg = pos % NPG;
    end else begin
      ech = int'(iSel);
      epg = int'(iPage);
    end
    w = '0;
    if (ech < NCH) w = (mode == 1) ? m_snap[ech] : ch[ech];
    d = (epg < NPG) ? 32'(w >> (32 * epg)) : 32'h0;
    b = '0;
    for (int i = 1; i < 8; i++)
      if ((d >> (4 * i)) == 0) b[i] = 1'b1;
    if (iCapture && !m_cap)
      for (int k = 0; k < NCH; k++) m_snap[k] = ch[k];
    m_cap  = iCapture;
    m_prev = mode;
    #1;
    check("digits", 64'(oDigits), 64'(d));
    check("blank", 64'(oBlank), 64'(b));
    check("channel", 64'(oChannel), 64'(ech[2:0]));
    check("page", 64'(oPage), 64'(epg[0:0]));
    check("frozen", 64'(oFrozen), 64'(mode == 1));
  endtask

  task automatic reset_check();
    check("rst_digits", 64'(oDigits), 64'h0);
    check("rst_blank", 64'(oBlank), 64'hFE);
    check("rst_channel", 64'(oChannel), 64'h0);
    check("rst_page", 64'(oPage), 64'h0);
    check("rst_frozen", 64'(oFrozen), 64'h0);
  endtask

  // Assert reset between edges and check the async clear at once.
  task automatic do_reset();
    @(posedge iClock);
    #2;
    iReset = 1'b1;
    #1;
    reset_check();
    model_reset();
    @(negedge iClock);
    iCapture = 1'b0;
    iReset = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    iReset = 1'b1;
    iSel = '0;
    iPage = '0;
    iMode = 2'd0;
    iCapture = 1'b0;
    for (int k = 0; k < NCH; k++) ch[k] = '0;
    model_reset();
    #12;
    reset_check();
    @(negedge iClock);
    iReset = 1'b0;
    cycle();

    // live paging
    ch[2] = 64'h0123_4567_89AB_CDEF;
    iSel = 3'd2;
    iPage = 1'b1;
    cycle();
    check("live_p1", 64'(oDigits), 64'h0123_4567);
    check("live_p1_blank", 64'(oBlank), 64'h80);
    iPage = 1'b0;
    cycle();
    check("live_p0", 64'(oDigits), 64'h89AB_CDEF);
    check("live_p0_blank", 64'(oBlank), 64'h00);

    // snapshot then hold
    ch[1] = 64'hDEAD;
    iCapture = 1'b1;
    cycle();
    iCapture = 1'b0;
    ch[1] = 64'hBEEF;
    iMode = 2'd1;
    iSel = 3'd1;
    iPage = 1'b0;
    cycle();
    check("hold_data", 64'(oDigits), 64'h0000_DEAD);
    check("hold_blank", 64'(oBlank), 64'hF0);
    check("hold_frozen", 64'(oFrozen), 64'h1);
    iMode = 2'd0;
    cycle();
    check("unhold_data", 64'(oDigits), 64'h0000_BEEF);

    // auto scroll full lap with a capture in the middle
    iSel = 3'd0;
    iPage = 1'b0;
    iMode = 2'd2;
    cycle();
    for (int c = 1; c <= 40; c++) begin
      iCapture = (c == 17);
      cycle();
      if (c == 5) begin
        check("auto_c5_ch", 64'(oChannel), 64'h0);
        check("auto_c5_pg", 64'(oPage), 64'h1);
      end
      if (c == 9) check("auto_c9_ch", 64'(oChannel), 64'h1);
    end
    iCapture = 1'b0;
    check("auto_lap_ch", 64'(oChannel), 64'h0);
    check("auto_lap_pg", 64'(oPage), 64'h0);

    // out of range channel
    iMode = 2'd0;
    iSel = 3'd6;
    iPage = 1'b0;
    cycle();
    check("oor_data", 64'(oDigits), 64'h0);
    check("oor_blank", 64'(oBlank), 64'hFE);
    check("oor_channel", 64'(oChannel), 64'h6);
    iPage = 1'b1;
    cycle();
    check("oor_p1_data", 64'(oDigits), 64'h0);

    // reset in the middle of auto at (3,1)
    iCapture = 1'b1;
    cycle();
    iCapture = 1'b0;
    iSel = 3'd0;
    iPage = 1'b0;
    iMode = 2'd2;
    cycle();
    for (int c = 1; c <= 29; c++) cycle();
    check("auto31_ch", 64'(oChannel), 64'h3);
    check("auto31_pg", 64'(oPage), 64'h1);
    do_reset();
    iMode = 2'd1;
    iSel = 3'd2;
    cycle();
    check("post_rst_snap", 64'(oDigits), 64'h0);
    iMode = 2'd2;
    iSel = 3'd0;
    iPage = 1'b0;
    cycle();
    check("post_rst_ch", 64'(oChannel), 64'h0);
    check("post_rst_pg", 64'(oPage), 64'h0);

    // randomized run
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(15) == 0) iMode = 2'($urandom_range(3));
      if ($urandom_range(7) == 0) iSel = 3'($urandom_range(7));
      if ($urandom_range(7) == 0) iPage = 1'($urandom_range(1));
      if ($urandom_range(3) == 0) iCapture = ~iCapture;
      for (int k = 0; k < NCH; k++)
        if ($urandom_range(9) == 0) begin
          ch[k] = {$urandom, $urandom};
          if ($urandom_range(2) == 0) ch[k] = ch[k] >> ($urandom_range(63));
        end
      if (c == 400) do_reset();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
